mips_main_control: RTL and testbench

//   Main decoder of the single-issue MIPS datapath: maps the 6-bit opcode (Instruction[31:26])
//   to datapath steering signals (register-file destination, ALU source and op class,

---
 rtl/mips_main_control_if.sv | 24 ++
 rtl/mips_main_control.sv | 142 ++++++++++++++
 tb/tb_mips_main_control.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_main_control_if.sv
// Opcode-in / control-word-out bundle between the decode stage and the main decoder.
// master = decode stage (drives the opcode), slave = main decoder (drives the control word).
interface mips_main_control_if;
    logic [5:0] Instruction;
    logic       RegDst;
    logic       Jump;
    logic       Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic [1:0] ALUOp;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;

    modport master (
        output Instruction,
        input  RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite
    );

    modport slave (
        input  Instruction,
        output RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite
    );
endinterface

// File: rtl/mips_main_control.sv
// Main decoder of the single-issue MIPS datapath: opcode -> registered control word.
// Unknown opcodes decode to an all-zero NOP word so no state-changing enable can leak out.
module mips_main_control (
    input  logic                 clk,
    input  logic                 rst,
    mips_main_control_if.slave   ctrl
);

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_word_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGI  = 2'b11;

    localparam ctrl_word_t CTRL_NOP = 10'b00_0000_0000;

    // Halfword loads/stores share the word encoding; sizing lives in the memory stage.
    function automatic ctrl_word_t decode_opcode(input logic [5:0] opcode);
        ctrl_word_t w;
        w = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                w.reg_dst   = 1'b1;
                w.alu_op    = ALU_FUNCT;
                w.reg_write = 1'b1;
            end
            OP_ADDI: begin
                w.alu_op    = ALU_ADD;
                w.alu_src   = 1'b1;
                w.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                w.alu_op    = ALU_LOGI;
                w.alu_src   = 1'b1;
                w.reg_write = 1'b1;
            end
            OP_BEQ: begin
                w.branch = 1'b1;
                w.alu_op = ALU_SUB;
            end
            OP_J: begin
                w.jump = 1'b1;
            end
            OP_LW, OP_LH: begin
                w.mem_read   = 1'b1;
                w.mem_to_reg = 1'b1;
                w.alu_op     = ALU_ADD;
                w.alu_src    = 1'b1;
                w.reg_write  = 1'b1;
            end
            OP_SW, OP_SH: begin
                w.mem_write = 1'b1;
                w.alu_op    = ALU_ADD;
                w.alu_src   = 1'b1;
            end
            default: begin
                w = CTRL_NOP;
            end
        endcase
        return w;
    endfunction

    ctrl_word_t decoded_s;
    ctrl_word_t ctrl_r;

    // Combinational decode of the incoming opcode.
    always_comb begin
        decoded_s = decode_opcode(ctrl.Instruction);
    end

    // Single register stage; reset clears the word asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r <= CTRL_NOP;
        end else begin
            ctrl_r <= decoded_s;
        end
    end

    assign ctrl.RegDst   = ctrl_r.reg_dst;
    assign ctrl.Jump     = ctrl_r.jump;
    assign ctrl.Branch   = ctrl_r.branch;
    assign ctrl.MemRead  = ctrl_r.mem_read;
    assign ctrl.MemtoReg = ctrl_r.mem_to_reg;
    assign ctrl.ALUOp    = ctrl_r.alu_op;
    assign ctrl.MemWrite = ctrl_r.mem_write;
    assign ctrl.ALUSrc   = ctrl_r.alu_src;
    assign ctrl.RegWrite = ctrl_r.reg_write;

    mips_main_control_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .jump     (ctrl_r.jump),
        .branch   (ctrl_r.branch),
        .mem_read (ctrl_r.mem_read),
        .mem_to_reg(ctrl_r.mem_to_reg),
        .mem_write(ctrl_r.mem_write),
        .reg_write(ctrl_r.reg_write)
    );

endmodule

// Invariants of the registered control word.
module mips_main_control_chk (
    input logic clk,
    input logic rst,
    input logic jump,
    input logic branch,
    input logic mem_read,
    input logic mem_to_reg,
    input logic mem_write,
    input logic reg_write
);

    a_mem_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
    a_pc_excl:  assert property (@(posedge clk) disable iff (rst) !(jump && branch));
    a_wb_mem:   assert property (@(posedge clk) disable iff (rst) (!mem_to_reg || mem_read));
    a_st_nowb:  assert property (@(posedge clk) disable iff (rst) (!mem_write || !reg_write));

endmodule

// File: tb/tb_mips_main_control.sv
// Directed-vector bench for mips_main_control with hand-computed control words.
// Word order: {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}.
module tb_mips_main_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mips_main_control_if bus ();

    mips_main_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    localparam logic [9:0] W_NOP  = 10'b0000000000;
    localparam logic [9:0] W_R    = 10'b1000010001;
    localparam logic [9:0] W_ADDI = 10'b0000000011;
    localparam logic [9:0] W_LOGI = 10'b0000011011;
    localparam logic [9:0] W_BEQ  = 10'b0010001000;
    localparam logic [9:0] W_J    = 10'b0100000000;
    localparam logic [9:0] W_LOAD = 10'b0001100011;
    localparam logic [9:0] W_STOR = 10'b0000000110;

    localparam int NV = 16;
    logic [5:0] vec_op  [NV] = '{6'h00, 6'h08, 6'h0D, 6'h0C, 6'h04, 6'h02, 6'h23, 6'h21,
                                 6'h2B, 6'h29, 6'h3F, 6'h20, 6'h2A, 6'h01, 6'h09, 6'h00};
    logic [9:0] vec_exp [NV] = '{W_R,   W_ADDI, W_LOGI, W_LOGI, W_BEQ, W_J,   W_LOAD, W_LOAD,
                                 W_STOR, W_STOR, W_NOP, W_NOP,  W_NOP, W_NOP, W_NOP,  W_R};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {bus.RegDst, bus.Jump, bus.Branch, bus.MemRead, bus.MemtoReg,
                bus.ALUOp, bus.MemWrite, bus.ALUSrc, bus.RegWrite};
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive an opcode away from the edge, then sample just after the next rising edge.
    task automatic apply(input logic [5:0] op);
        @(negedge clk);
        bus.Instruction = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        bus.Instruction = 6'h00;

        #1 rst = 1'b1;
        #1 check_eq("reset_async", observed(), W_NOP);
        @(posedge clk);
        #1 check_eq("reset_held", observed(), W_NOP);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_eq("first_after_reset", observed(), W_R);

        // Back-to-back: each edge carries a different opcode.
        for (int i = 0; i < NV; i++) begin
            apply(vec_op[i]);
            check_eq($sformatf("op_%02h", vec_op[i]), observed(), vec_exp[i]);
        end

        // Mid-cycle opcode change must not reach the outputs before the next edge.
        apply(6'h08);
        check_eq("addi_loaded", observed(), W_ADDI);
        bus.Instruction = 6'h2B;
        #3 check_eq("hold_mid_cycle", observed(), W_ADDI);
        @(posedge clk);
        #1 check_eq("sw_after_edge", observed(), W_STOR);

        // Reset mid-stream while a load word is registered.
        apply(6'h23);
        check_eq("lw_loaded", observed(), W_LOAD);
        #2 rst = 1'b1;
        #1 check_eq("reset_mid_stream", observed(), W_NOP);
        @(posedge clk);
        #1 check_eq("reset_mid_hold", observed(), W_NOP);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_eq("lw_after_release", observed(), W_LOAD);

        apply(6'h04);
        check_eq("beq_after_release", observed(), W_BEQ);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
